vx_tcu_drl_excep_fixup: RTL and testbench
=========================================

# VX_tcu_drl_excep_fixup

Pipelined exception-alignment and result-fixup stage for the TCU DRL FEDP datapath. Captures the per-lane special-case exception summary (`fedp_excep_t`) produced in the FEDP front end. Delays it in lock-step with the arithmetic pipeline, then overrides the FP32 datapath result with canonical NaN/±Inf where required. Sits between the FEDP accumulator output and the TCU writeback register.

## Interface
Parameters:
- `LANES`, 1: independent dot-product lanes (one `fedp_excep_t` and one FP32 result each)
- `LATENCY`, 4: enable-cycles between `excep_valid` and matching `result_valid`; legal range 1..16

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-low reset
- `enable`  in  1  pipeline advance; 0 = stall, all state held
- `excep_valid`  in  1  exception word valid this enable-cycle
- `excep_in`  in  `LANES*$bits(fedp_excep_t)`  {sign, is_nan, is_inf} per lane
- `result_valid`  in  1  datapath result valid (arrives `LATENCY` enable-cycles after its `excep_valid`)
- `result_in`  in  `LANES*32`  raw FP32 datapath results
- `out_valid`  out  1  fixed-up result valid
- `out_data`  out  `LANES*32`  fixed-up FP32 results
- `out_excep`  out  `LANES*2`  per lane {is_nan, is_inf} as applied
- `align_err`  out  1  sticky: `result_valid` disagreed with delayed valid
- `err_clr`  in  1  clears `align_err`

## Operation
- Delay line: `LATENCY`-entry shift register of {valid, excep[LANES]}, advancing only when `enable`=1. Entry 0 loads {`excep_valid`, `excep_in`}; the tail entry is aligned with `result_in`.
- Per-lane fixup at tail, registered into outputs when `enable`=1:
  - is_nan=1 → `32'h7FC00000` (sign ignored)
  - else is_inf=1 → sign ? `32'hFF800000` : `32'h7F800000`
  - else → `result_in` passthrough, bit-exact
  - Invalid word with is_nan and is_inf both set is treated as NaN.
- `out_valid` <= tail valid. `out_data`/`out_excep` load only when tail valid=1; otherwise hold previous value.
- Alignment check: on an enable-cycle where `result_valid` ≠ tail valid, set `align_err`. Output still follows tail valid; data from a lone `result_valid` is discarded. `err_clr` and a new error in the same cycle → `align_err`=1 (set wins).
- No backpressure from downstream: the consumer must accept every `out_valid` cycle. Stalls are upstream-driven via `enable`.

## Timing
- Reset (`reset`=0 at posedge): all delay-line valids 0, `out_valid`=0, `out_data`=0, `out_excep`=0, `align_err`=0, stats counters 0. Reset overrides `enable`.
- Reset mid-operation drops all in-flight words. No partial outputs afterwards.
- Latency: `excep_valid` accepted at enable-cycle k → `out_valid`=1 after the posedge of enable-cycle k+`LATENCY`. That is `LATENCY`+1 enable-cycles total, with the output registered.
- `enable`=0: every register, including outputs, holds. `out_valid` remains asserted if it was, so the consumer qualifies with `enable`.
- Back-to-back: one word per enable-cycle sustained. No bubbles inserted.

## Configuration
- `VX_TCU_EXCEP_STATS_EN`:
  - Defined: adds outputs `stat_nan` [15:0] and `stat_inf` [15:0], plus input `stat_clr`.
  - Counters increment once per output word containing ≥1 NaN-overridden lane (resp. ≥1 Inf-overridden lane, NaN not set). They saturate at `16'hFFFF`.
  - `stat_clr` zeroes the counters and wins over a same-cycle increment.
  - Undefined: ports and counters absent. Behaviour otherwise identical.

## Test plan
- LATENCY=4, LANES=1: excep {0,0,0} with result `32'h3F800000` → `out_data`=`32'h3F800000` exactly 5 enable-cycles later, `out_excep`=0.
- excep {sign=1, is_inf=1} → `out_data`=`32'hFF800000`; excep {is_nan=1, sign=1} → `32'h7FC00000`, regardless of `result_in`.
- Stream of 8 words with `enable` toggling 1,0,0,1,...: outputs appear in order, counted in enable-cycles only, and hold while stalled.
- Inject `result_valid`=1 with no matching excep → `align_err`=1 and no `out_valid`. Then `err_clr` → `align_err`=0.
- Assert `reset`=0 with 3 words in flight → `out_valid` stays 0 for the next 6 cycles after release.
- With `VX_TCU_EXCEP_STATS_EN`: 70000 NaN words → `stat_nan`=`16'hFFFF`. Then `stat_clr` together with a NaN word → 0.

Source files
------------

// File: rtl/vx_tcu_drl_excep_fixup_if.sv
// Bus between the FEDP datapath and the exception fixup stage.
// Stats signals exist only when VX_TCU_EXCEP_STATS_EN is defined.
interface vx_tcu_drl_excep_fixup_if #(
  parameter int LANES = 1
);
  logic                  enable;
  logic                  excep_valid;
  logic [LANES*3-1:0]    excep_in;
  logic                  result_valid;
  logic [LANES*32-1:0]   result_in;
  logic                  out_valid;
  logic [LANES*32-1:0]   out_data;
  logic [LANES*2-1:0]    out_excep;
  logic                  align_err;
  logic                  err_clr;
`ifdef VX_TCU_EXCEP_STATS_EN
  logic                  stat_clr;
  logic [15:0]           stat_nan;
  logic [15:0]           stat_inf;

  modport master (
    output enable, excep_valid, excep_in, result_valid, result_in, err_clr, stat_clr,
    input  out_valid, out_data, out_excep, align_err, stat_nan, stat_inf
  );
  modport slave (
    input  enable, excep_valid, excep_in, result_valid, result_in, err_clr, stat_clr,
    output out_valid, out_data, out_excep, align_err, stat_nan, stat_inf
  );
`else
  modport master (
    output enable, excep_valid, excep_in, result_valid, result_in, err_clr,
    input  out_valid, out_data, out_excep, align_err
  );
  modport slave (
    input  enable, excep_valid, excep_in, result_valid, result_in, err_clr,
    output out_valid, out_data, out_excep, align_err
  );
`endif
endinterface

// File: rtl/vx_tcu_drl_excep_fixup.sv
// FEDP exception alignment + FP32 result fixup (canonical NaN / signed Inf).
// Optional saturating NaN/Inf word counters: define VX_TCU_EXCEP_STATS_EN.

module vx_tcu_drl_excep_fixup_lane (
  input  logic        sign_i,
  input  logic        nan_i,
  input  logic        inf_i,
  input  logic [31:0] result_i,
  output logic [31:0] data_o,
  output logic [1:0]  excep_o
);
  // NaN has priority, so a malformed {nan,inf} word still yields a NaN
  always_comb begin
    data_o  = result_i;
    excep_o = 2'b00;
    if (nan_i) begin
      data_o  = 32'h7FC0_0000;
      excep_o = 2'b10;
    end else if (inf_i) begin
      data_o  = sign_i ? 32'hFF80_0000 : 32'h7F80_0000;
      excep_o = 2'b01;
    end
  end
endmodule

module vx_tcu_drl_excep_fixup #(
  parameter int LANES   = 1,
  parameter int LATENCY = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  vx_tcu_drl_excep_fixup_if.slave   bus
);
  typedef struct packed {
    logic sign;
    logic is_nan;
    logic is_inf;
  } fedp_excep_t;

  logic [LATENCY-1:0]                    vld_q, vld_d;
  fedp_excep_t [LATENCY-1:0][LANES-1:0]  exc_q, exc_d;
  fedp_excep_t [LANES-1:0]               exc_in, tail_exc;
  logic                                  tail_vld;

  logic [LANES-1:0][31:0]                res_in, fix_data;
  logic [LANES-1:0][1:0]                 fix_exc;

  logic                                  out_valid_q;
  logic [LANES*32-1:0]                   out_data_q, out_data_d;
  logic [LANES*2-1:0]                    out_excep_q, out_excep_d;
  logic                                  align_err_q, align_err_d;

  assign exc_in   = bus.excep_in;
  assign res_in   = bus.result_in;
  assign tail_vld = vld_q[LATENCY-1];
  assign tail_exc = exc_q[LATENCY-1];

  always_comb begin
    vld_d    = vld_q;
    exc_d    = exc_q;
    vld_d[0] = bus.excep_valid;
    exc_d[0] = exc_in;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      exc_d[i] = exc_q[i-1];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vx_tcu_drl_excep_fixup_lane u_lane (
      .sign_i   (tail_exc[g].sign),
      .nan_i    (tail_exc[g].is_nan),
      .inf_i    (tail_exc[g].is_inf),
      .result_i (res_in[g]),
      .data_o   (fix_data[g]),
      .excep_o  (fix_exc[g])
    );
  end

  // A lone result_valid is flagged but its data never reaches the output
  always_comb begin
    out_data_d  = tail_vld ? fix_data : out_data_q;
    out_excep_d = tail_vld ? fix_exc  : out_excep_q;
    align_err_d = (bus.result_valid != tail_vld) | (align_err_q & ~bus.err_clr);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q       <= '0;
      exc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_excep_q <= '0;
      align_err_q <= 1'b0;
    end else if (bus.enable) begin
      vld_q       <= vld_d;
      exc_q       <= exc_d;
      out_valid_q <= tail_vld;
      out_data_q  <= out_data_d;
      out_excep_q <= out_excep_d;
      align_err_q <= align_err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_excep = out_excep_q;
  assign bus.align_err = align_err_q;

`ifdef VX_TCU_EXCEP_STATS_EN
  logic        any_nan, any_inf;
  logic [15:0] stat_nan_q, stat_nan_d, stat_inf_q, stat_inf_d;

  always_comb begin
    any_nan = 1'b0;
    any_inf = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      any_nan = any_nan | fix_exc[l][1];
      any_inf = any_inf | fix_exc[l][0];
    end
    stat_nan_d = stat_nan_q;
    stat_inf_d = stat_inf_q;
    if (bus.stat_clr) begin
      stat_nan_d = '0;
      stat_inf_d = '0;
    end else if (tail_vld) begin
      if (any_nan && stat_nan_q != 16'hFFFF) stat_nan_d = stat_nan_q + 16'd1;
      if (any_inf && stat_inf_q != 16'hFFFF) stat_inf_d = stat_inf_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_nan_q <= '0;
      stat_inf_q <= '0;
    end else if (bus.enable) begin
      stat_nan_q <= stat_nan_d;
      stat_inf_q <= stat_inf_d;
    end
  end

  assign bus.stat_nan = stat_nan_q;
  assign bus.stat_inf = stat_inf_q;
`endif

endmodule

// File: tb/tb_vx_tcu_drl_excep_fixup.sv
// Directed + random bench for vx_tcu_drl_excep_fixup against a queue-based model.
module tb_vx_tcu_drl_excep_fixup;
  localparam int L   = 2;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vx_tcu_drl_excep_fixup_if #(.LANES(L)) bus ();
  vx_tcu_drl_excep_fixup #(.LANES(L), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic             v;
    logic [L*3-1:0]   e;
  } ent_t;

  ent_t              pipe_q[$];
  logic              m_ov;
  logic [L*32-1:0]   m_data;
  logic [L*2-1:0]    m_exc;
  logic              m_err;
  int                m_nan, m_inf;

  function automatic void lane_fix(input logic [2:0] e, input logic [31:0] r,
                                   output logic [31:0] d, output logic [1:0] x);
    if (e[1]) begin d = 32'h7FC0_0000; x = 2'b10; end
    else if (e[0]) begin d = e[2] ? 32'hFF80_0000 : 32'h7F80_0000; x = 2'b01; end
    else begin d = r; x = 2'b00; end
  endfunction

  task automatic model_edge(input logic sclr);
    ent_t        t;
    logic [31:0] d;
    logic [1:0]  x;
    logic        an, ai;
    if (!rst_n) begin
      pipe_q.delete();
      m_ov = 0; m_data = '0; m_exc = '0; m_err = 0; m_nan = 0; m_inf = 0;
    end else if (bus.enable) begin
      t.v = 1'b0; t.e = '0;
      if (pipe_q.size() == LAT) t = pipe_q.pop_front();
      m_ov = t.v;
      an = 0; ai = 0;
      if (t.v) begin
        for (int l = 0; l < L; l++) begin
          lane_fix(t.e[l*3 +: 3], bus.result_in[l*32 +: 32], d, x);
          m_data[l*32 +: 32] = d;
          m_exc[l*2 +: 2]    = x;
          an |= x[1];
          ai |= x[0];
        end
      end
      if (sclr) begin
        m_nan = 0; m_inf = 0;
      end else begin
        if (an && m_nan < 65535) m_nan++;
        if (ai && m_inf < 65535) m_inf++;
      end
      m_err = (bus.result_valid != t.v) || (m_err && !bus.err_clr);
      pipe_q.push_back('{bus.excep_valid, bus.excep_in});
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", {63'd0, bus.out_valid}, {63'd0, m_ov});
    chk("out_data",  bus.out_data, m_data);
    chk("out_excep", {60'd0, bus.out_excep}, {60'd0, m_exc});
    chk("align_err", {63'd0, bus.align_err}, {63'd0, m_err});
  endtask

  logic sclr_g = 1'b0;

  // rv follows the model's tail valid unless flip=1 (deliberate misalignment)
  task automatic run(input logic en, input logic ev, input logic [L*3-1:0] e,
                     input logic [L*32-1:0] r, input logic flip, input logic clr);
    logic tv;
    tv = (pipe_q.size() == LAT) && pipe_q[0].v;
    bus.enable = en; bus.excep_valid = ev; bus.excep_in = e;
    bus.result_valid = tv ^ flip; bus.result_in = r; bus.err_clr = clr;
`ifdef VX_TCU_EXCEP_STATS_EN
    bus.stat_clr = sclr_g;
`endif
    @(posedge clk);
    model_edge(sclr_g);
    #1;
    check_all();
  endtask

  initial begin : main
    int fed, seen, k;
    logic [31:0] rnd;
    rst_n = 1'b0;
    bus.enable = 0; bus.excep_valid = 0; bus.excep_in = '0;
    bus.result_valid = 0; bus.result_in = '0; bus.err_clr = 0;
`ifdef VX_TCU_EXCEP_STATS_EN
    bus.stat_clr = 0;
`endif
    // reset state
    run(1, 1, '1, '1, 0, 0);
    run(0, 0, '0, '0, 0, 0);
    chk("rst_ov",   {63'd0, bus.out_valid}, 64'd0);
    chk("rst_data", bus.out_data, 64'd0);
    chk("rst_err",  {63'd0, bus.align_err}, 64'd0);
    rst_n = 1'b1;

    // latency: passthrough word appears LAT+1 enable-cycles after issue
    run(1, 1, '0, '0, 0, 0);
    for (int i = 0; i < LAT-1; i++) begin
      run(1, 0, '0, '0, 0, 0);
      chk("lat_idle", {63'd0, bus.out_valid}, 64'd0);
    end
    run(1, 0, '0, {32'h4000_0000, 32'h3F80_0000}, 0, 0);
    chk("lat_ov",   {63'd0, bus.out_valid}, 64'd1);
    chk("lat_data", bus.out_data, {32'h4000_0000, 32'h3F80_0000});
    chk("lat_exc",  {60'd0, bus.out_excep}, 64'd0);

    // lane0 {sign,inf} -> -Inf, lane1 {sign,nan} -> NaN; then {nan,inf} both -> NaN
    run(1, 1, {3'b110, 3'b101}, '0, 0, 0);
    run(1, 1, {3'b011, 3'b001}, '0, 0, 0);
    for (int i = 0; i < LAT-2; i++) run(1, 0, '0, '0, 0, 0);
    run(1, 0, '0, {$urandom, $urandom}, 0, 0);
    chk("inf_neg_nan", bus.out_data, {32'h7FC0_0000, 32'hFF80_0000});
    chk("inf_neg_exc", {60'd0, bus.out_excep}, {60'd0, 4'b1001});
    run(1, 0, '0, {$urandom, $urandom}, 0, 0);
    chk("both_nan_posinf", bus.out_data, {32'h7FC0_0000, 32'h7F80_0000});
    for (int i = 0; i < LAT; i++) run(1, 0, '0, '0, 0, 0);

    // 8-word stream under enable pattern 1,0,0,1,0,0,...
    fed = 0; seen = 0; k = 0;
    for (int c = 0; c < 120 && seen < 8; c++) begin
      logic en, tv;
      en = (c % 3 == 0);
      tv = (pipe_q.size() == LAT) && pipe_q[0].v;
      run(en, en && (k < 8), '0, {32'd0, 32'hA000_0000 + fed}, 0, 0);
      if (en && k < 8) k++;
      if (en && tv) fed++;
      if (en && bus.out_valid) begin
        chk("stream_order", {32'd0, bus.out_data[31:0]}, {32'd0, 32'hA000_0000 + seen});
        seen++;
      end
    end
    chk("stream_count", 64'(seen), 64'd8);

    // alignment error: lone result_valid, clear, set-wins-over-clear
    run(1, 0, '0, {$urandom, $urandom}, 1, 0);
    chk("align_set", {62'd0, bus.align_err, bus.out_valid}, 64'b10);
    run(1, 0, '0, '0, 0, 1);
    chk("align_clr", {63'd0, bus.align_err}, 64'd0);
    run(1, 0, '0, '0, 1, 1);
    chk("align_setwin", {63'd0, bus.align_err}, 64'd1);
    run(1, 0, '0, '0, 0, 1);

    // reset with 3 words in flight
    for (int i = 0; i < 3; i++) run(1, 1, '0, '0, 0, 0);
    rst_n = 1'b0;
    run(1, 0, '0, '0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run(1, 0, '0, {$urandom, $urandom}, 0, 0);
      chk("rst_flush", {63'd0, bus.out_valid}, 64'd0);
    end

    // random traffic
    for (int c = 0; c < 400; c++) begin
      rnd = $urandom;
      run(rnd[1:0] != 0, rnd[2], 6'($urandom_range(0, 63)), {$urandom, $urandom},
          rnd[7:3] == 0, rnd[11:8] == 0);
    end

`ifdef VX_TCU_EXCEP_STATS_EN
    sclr_g = 1;
    run(1, 0, '0, '0, 0, 1);
    sclr_g = 0;
    for (int i = 0; i < 70000; i++) run(1, 1, {3'b010, 3'b000}, '0, 0, 0);
    chk("stat_nan_sat", {48'd0, bus.stat_nan}, 64'h0000_0000_0000_FFFF);
    chk("stat_nan_mdl", {48'd0, bus.stat_nan}, 64'(m_nan));
    chk("stat_inf_mdl", {48'd0, bus.stat_inf}, 64'(m_inf));
    sclr_g = 1;
    run(1, 1, {3'b010, 3'b000}, '0, 0, 0);
    sclr_g = 0;
    chk("stat_clr_win", {48'd0, bus.stat_nan}, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
